risc_shifter: RTL and testbench

- 32-bit barrel shifter for the RISC datapath execute stage.
- Shifts operand D1 left or right by the amount in D2, selected by one-hot control strobes SLI/SRI.
- The result is registered and appears on DOut one clock after the inputs are sampled.
- Purely combinational shift network (five log stages) followed by an output register and a valid flag.

---
 rtl/risc_shifter.sv | 76 +++++++
 tb/tb_risc_shifter.sv | 131 +++++++++++++
 2 files changed

// File: rtl/risc_shifter.sv
// Registered 32-bit barrel shifter: five log stages, right shifts reuse the left network via bit reversal.
// Define SHIFTER_ARITH_EN to make SRI an arithmetic (sign-filling) right shift.
module risc_shifter #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] D1,
  input  logic [WIDTH-1:0] D2,
  input  logic             SLI,
  input  logic             SRI,
  output logic [WIDTH-1:0] DOut,
  output logic             DValid
);

  logic               do_left;
  logic               do_right;
  logic               fill;
  logic               oversize;
  logic [SHAMT_W-1:0] amt;
  logic [WIDTH-1:0]   d1_rev;
  logic [WIDTH-1:0]   net_out;
  logic [WIDTH-1:0]   res_rev;
  logic [WIDTH-1:0]   shifted;
  logic [WIDTH-1:0]   dout_next;
  logic [WIDTH-1:0]   stage [SHAMT_W+1];

  assign do_left  = SLI & ~SRI;
  assign do_right = SRI & ~SLI;
  assign amt      = D2[SHAMT_W-1:0];
  assign oversize = |D2[WIDTH-1:SHAMT_W];

`ifdef SHIFTER_ARITH_EN
  assign fill = do_right & D1[WIDTH-1];
`else
  assign fill = 1'b0;
`endif

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_rev
      assign d1_rev[gi]  = D1[WIDTH-1-gi];
      assign res_rev[gi] = net_out[WIDTH-1-gi];
    end

    // Fill enters at the LSB; in the reversed domain that becomes the MSB of a right shift.
    assign stage[0] = do_right ? d1_rev : D1;
    for (gi = 0; gi < SHAMT_W; gi++) begin : g_stage
      localparam int S = 1 << gi;
      assign stage[gi+1] = amt[gi] ? {stage[gi][WIDTH-1-S:0], {S{fill}}} : stage[gi];
    end
  endgenerate

  assign net_out = stage[SHAMT_W];
  assign shifted = do_right ? res_rev : net_out;

  always_comb begin
    dout_next = D1;
    if (do_left || do_right) begin
      if (oversize) dout_next = {WIDTH{fill}};
      else          dout_next = shifted;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      DOut   <= '0;
      DValid <= 1'b0;
    end else begin
      DOut   <= dout_next;
      DValid <= SLI ^ SRI;
    end
  end

endmodule

// File: tb/tb_risc_shifter.sv
// Self-checking bench for risc_shifter: directed cases, streaming, async reset and random vectors
// compared against a plain-arithmetic reference model.
module tb_risc_shifter;

  logic        clk;
  logic        rst_n;
  logic [31:0] D1;
  logic [31:0] D2;
  logic        SLI;
  logic        SRI;
  logic [31:0] DOut;
  logic        DValid;

  int n_vec;
  int n_miss;

  risc_shifter #(.WIDTH(32), .SHAMT_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .D1(D1), .D2(D2), .SLI(SLI), .SRI(SRI),
    .DOut(DOut), .DValid(DValid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reference: result and valid derived directly from the operation rules.
  function automatic logic [32:0] ref_shift(input logic [31:0] d1, input logic [31:0] d2,
                                            input logic sli, input logic sri);
    logic [31:0] r;
    r = d1;
    if (sli && !sri) begin
      r = (d2 >= 32) ? 32'h0 : (d1 << d2);
    end else if (sri && !sli) begin
`ifdef SHIFTER_ARITH_EN
      r = (d2 >= 32) ? {32{d1[31]}} : 32'($signed(d1) >>> d2);
`else
      r = (d2 >= 32) ? 32'h0 : (d1 >> d2);
`endif
    end
    return {sli ^ sri, r};
  endfunction

  // Drive one vector, let it be sampled, then compare #1 after the edge.
  task automatic apply(input string tag, input logic [31:0] d1, input logic [31:0] d2,
                       input logic sli, input logic sri);
    logic [32:0] e;
    D1 = d1; D2 = d2; SLI = sli; SRI = sri;
    e = ref_shift(d1, d2, sli, sri);
    @(posedge clk);
    #1;
    check({tag, "_dout"}, DOut, e[31:0]);
    check({tag, "_valid"}, {31'h0, DValid}, {31'h0, e[32]});
  endtask

  initial begin
    logic [31:0] rd1, rd2;
    logic        rsl, rsr;
    n_vec  = 0;
    n_miss = 0;

    rst_n = 1'b0; D1 = 32'h1; D2 = 32'h1; SLI = 1'b1; SRI = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_dout", DOut, 32'h0);
    check("rst_valid", {31'h0, DValid}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_dout", DOut, 32'h2);
    check("post_rst_valid", {31'h0, DValid}, 32'h1);

    apply("pass", 32'h1, 32'h1, 1'b0, 1'b0);
    check("pass_const", DOut, 32'h1);
    apply("sl1", 32'h1, 32'd1, 1'b1, 1'b0);
    apply("sl31", 32'h1, 32'd31, 1'b1, 1'b0);
    check("sl31_const", DOut, 32'h8000_0000);
    apply("sl32", 32'h1, 32'd32, 1'b1, 1'b0);
    apply("sr1", 32'h1, 32'd1, 1'b0, 1'b1);
    apply("srneg", 32'hFFFF_FFFE, 32'd1, 1'b0, 1'b1);
`ifdef SHIFTER_ARITH_EN
    check("srneg_const", DOut, 32'hFFFF_FFFF);
`else
    check("srneg_const", DOut, 32'h7FFF_FFFF);
`endif
    apply("srbig", 32'h8000_0001, 32'h0001_0000, 1'b0, 1'b1);
    apply("illegal", 32'h1234, 32'd3, 1'b1, 1'b1);
    check("illegal_const", DOut, 32'h1234);
    apply("zero_amt", 32'hA5A5_A5A5, 32'd0, 1'b1, 1'b0);
    apply("sr31", 32'h8000_0000, 32'd31, 1'b0, 1'b1);

    for (int n = 0; n < 32; n++) begin
      apply("stream", 32'h1, 32'(n), 1'b1, 1'b0);
      check("stream_const", DOut, 32'h1 << n);
    end

    // Async reset dropped between edges must clear the outputs immediately.
    D1 = 32'hDEAD_BEEF; D2 = 32'd4; SLI = 1'b1; SRI = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_dout", DOut, 32'h0);
    check("async_rst_valid", {31'h0, DValid}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    apply("after_async", 32'hDEAD_BEEF, 32'd4, 1'b1, 1'b0);

    for (int i = 0; i < 400; i++) begin
      rd1 = $urandom;
      case ($urandom_range(0, 3))
        0:       rd2 = $urandom;
        1:       rd2 = 32'($urandom_range(0, 40));
        default: rd2 = 32'($urandom_range(0, 31));
      endcase
      rsl = 1'($urandom_range(0, 1));
      rsr = 1'($urandom_range(0, 1));
      apply("rand", rd1, rd2, rsl, rsr);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
